// File: rtl/uart_pkg.sv
// Shared constants, state type and helpers for the UART transmit path.
// Holds frame length, divisor lookup (100 MHz clock) and parity helper.
package uart_pkg;

    localparam int DIV_W      = 19;
    localparam int FRAME_BITS = 11;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Bit-time divisor for a 100 MHz clock; indices 12..15 reuse 109.
    function automatic logic [DIV_W-1:0] baud_div(input logic [3:0] sel);
        logic [DIV_W-1:0] d;
        case (sel)
            4'd0:    d = DIV_W'(333333);
            4'd1:    d = DIV_W'(83333);
            4'd2:    d = DIV_W'(41667);
            4'd3:    d = DIV_W'(20833);
            4'd4:    d = DIV_W'(10417);
            4'd5:    d = DIV_W'(5208);
            4'd6:    d = DIV_W'(2604);
            4'd7:    d = DIV_W'(1736);
            4'd8:    d = DIV_W'(868);
            4'd9:    d = DIV_W'(434);
            4'd10:   d = DIV_W'(217);
            default: d = DIV_W'(109);
        endcase
        return d;
    endfunction

    // Parity over the data bits actually sent (bit7 excluded in 7-bit mode).
    function automatic logic parity(
        input logic [7:0] data,
        input logic       eight,
        input logic       ohel
    );
        logic [7:0] used;
        used = eight ? data : {1'b0, data[6:0]};
        return ohel ? ~^used : ^used;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: pulses btu for one cycle every div clocks while run=1.
// Ports: clk, reset (async, high), run, div -> btu.
module uart_baud_gen #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             btu
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign btu = run && (cnt_q == div - DIV_W'(1));

    // Held at zero while stopped so every run starts a full bit time.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (btu) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on load/txrdy, shifts an 11-bit frame out on tx.
// Ports: clk, reset, load, data_in, baud_sel, eight, pen, ohel [, brk] -> tx, txrdy, busy.
// Optional: define UART_TX_BREAK_EN to add the brk input (break holds tx low while idle).
module uart_tx_ctrl
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic [3:0] baud_sel,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
`ifdef UART_TX_BREAK_EN
    input  logic       brk,
`endif
    output logic       tx,
    output logic       txrdy,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [3:0]  baud_q, baud_d;
    logic [10:0] sreg_q, sreg_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        tx_q, tx_d;
    logic        txrdy_q, txrdy_d;
    logic        busy_q, busy_d;
    logic        btu;
    logic        brk_w;
    logic        d7;
    logic        par;

`ifdef UART_TX_BREAK_EN
    assign brk_w = brk;
`else
    assign brk_w = 1'b0;
`endif

    assign tx    = tx_q;
    assign txrdy = txrdy_q;
    assign busy  = busy_q;

    // eight/pen/ohel only shape the frame image built at accept time,
    // so the shift register itself is their latched copy.
    assign d7  = eight ? data_in[7] : 1'b1;
    assign par = pen ? parity(data_in, eight, ohel) : 1'b1;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .run  (state_q == SHIFT),
        .div  (baud_div(baud_q)),
        .btu  (btu)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        txrdy_d  = txrdy_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (brk_w) begin
                    tx_d    = 1'b0;
                    txrdy_d = 1'b0;
                    busy_d  = 1'b1;
                end else if (load && txrdy_q) begin
                    state_d  = SHIFT;
                    baud_d   = baud_sel;
                    sreg_d   = {1'b1, par, d7, data_in[6:0], 1'b0};
                    bitcnt_d = '0;
                    tx_d     = 1'b0;
                    txrdy_d  = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    txrdy_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (btu) begin
                    sreg_d   = {1'b1, sreg_q[10:1]};
                    tx_d     = sreg_q[1];
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        tx_d     = 1'b1;
                        txrdy_d  = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            sreg_q   <= '1;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            txrdy_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            txrdy_q  <= txrdy_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl (default build, no break input).
// Table of frames with hand-computed bit images plus directed corner sequences.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] baud_sel;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       tx;
    logic       txrdy;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (data_in),
        .baud_sel(baud_sel),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .tx      (tx),
        .txrdy   (txrdy),
        .busy    (busy)
    );

    // f holds the frame as sent: f[0]=start, f[8:1]=data slots, f[9]=parity, f[10]=stop
    typedef struct {
        logic [7:0]  d;
        logic [3:0]  b;
        logic        e;
        logic        p;
        logic        o;
        int          div;
        logic [10:0] f;
    } vec_t;

    vec_t vecs[7];
    vec_t nxt;
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        data_in  = v.d;
        baud_sel = v.b;
        eight    = v.e;
        pen      = v.p;
        ohel     = v.o;
    endtask

    task automatic start_frame(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        check({name, "_accept"}, {29'd0, tx, txrdy, busy}, 32'b001);
    endtask

    // Starts one sample after the accepting edge (n=0); samples mid-bit.
    // mode[0]: stray load + changed config at n=100.
    // mode[1]: load held high with nxt inputs from 5 clocks before frame end.
    task automatic capture(input int div, input int mode, input string name,
                           output logic [10:0] bits, output int len);
        int n;
        bit bad;
        n    = 0;
        bad  = 1'b0;
        bits = '0;
        len  = -1;
        while (n <= 11 * div + 50) begin
            if ((n % div) == div / 2 && n / div < 11) bits[n / div] = tx;
            if (busy === txrdy) bad = 1'b1;
            if (txrdy === 1'b1) begin
                len = n;
                break;
            end
            if (mode[0] && n == 100) begin
                data_in  = 8'h00;
                baud_sel = 4'd0;
                eight    = 1'b0;
                pen      = 1'b1;
                ohel     = 1'b1;
                load     = 1'b1;
            end
            if (mode[0] && n == 101) load = 1'b0;
            if (mode[1] && n == 11 * div - 5) begin
                drive(nxt);
                load = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_busy"}, {31'd0, bad}, 32'd0);
    endtask

    logic [10:0] bits;
    int          len;

    initial begin
        vecs[0] = '{8'h55, 4'd8,  1'b1, 1'b1, 1'b0, 868, 11'b1_0_01010101_0};
        vecs[1] = '{8'hC3, 4'd11, 1'b0, 1'b1, 1'b1, 109, 11'b1_0_11000011_0};
        vecs[2] = '{8'h80, 4'd13, 1'b0, 1'b0, 1'b0, 109, 11'b1_1_10000000_0};
        vecs[3] = '{8'hA7, 4'd10, 1'b1, 1'b1, 1'b1, 217, 11'b1_0_10100111_0};
        vecs[4] = '{8'h01, 4'd15, 1'b1, 1'b1, 1'b0, 109, 11'b1_1_00000001_0};
        vecs[5] = '{8'hFF, 4'd9,  1'b0, 1'b1, 1'b0, 434, 11'b1_1_11111111_0};
        vecs[6] = '{8'h3C, 4'd12, 1'b0, 1'b1, 1'b0, 109, 11'b1_0_10111100_0};

        reset    = 1'b1;
        load     = 1'b1;
        data_in  = 8'hA5;
        baud_sel = 4'd11;
        eight    = 1'b1;
        pen      = 1'b1;
        ohel     = 1'b1;

        // reset with load held: outputs stay idle
        #1;
        check("reset_early", {29'd0, tx, txrdy, busy}, 32'b110);
        repeat (5) @(posedge clk);
        #1;
        check("reset_load_held", {29'd0, tx, txrdy, busy}, 32'b110);
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {29'd0, tx, txrdy, busy}, 32'b110);

        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i], $sformatf("v%0d", i));
            capture(vecs[i].div, 0, $sformatf("v%0d", i), bits, len);
            check($sformatf("v%0d_bits", i), {21'd0, bits}, {21'd0, vecs[i].f});
            check($sformatf("v%0d_len", i), len, 11 * vecs[i].div);
        end

        // stray load mid-frame, then load held across the frame end
        nxt = vecs[6];
        start_frame(vecs[1], "ign");
        capture(vecs[1].div, 3, "ign", bits, len);
        check("ign_bits", {21'd0, bits}, {21'd0, vecs[1].f});
        check("ign_len", len, 11 * vecs[1].div);
        @(posedge clk);
        #1;
        check("held_accept", {29'd0, tx, txrdy, busy}, 32'b001);
        load = 1'b0;
        capture(vecs[6].div, 0, "held", bits, len);
        check("held_bits", {21'd0, bits}, {21'd0, vecs[6].f});
        check("held_len", len, 11 * vecs[6].div);

        // asynchronous reset during bit 5
        start_frame(vecs[3], "rst");
        repeat (5 * 217 + 50) @(posedge clk);
        #1;
        check("rst_pre_bit5", {31'd0, tx}, {31'd0, vecs[3].f[5]});
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", {29'd0, tx, txrdy, busy}, 32'b110);
        @(negedge clk);
        reset = 1'b0;
        start_frame(vecs[4], "post");
        capture(vecs[4].div, 0, "post", bits, len);
        check("post_bits", {21'd0, bits}, {21'd0, vecs[4].f});
        check("post_len", len, 11 * vecs[4].div);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
